fft_power_spectrum: RTL and testbench

//  Downstream of the 3-stage radix-2 FFT (top_fft). Consumes the two-bins-per-beat

---
 rtl/fft_power_spectrum.sv | 155 +++++++++++++++
 tb/tb_fft_power_spectrum.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_power_spectrum.sv
// Power spectrum of the two-bins-per-beat FFT output: |X[k]|^2 per bin,
// buffered for one frame, then streamed as bins 0..N/2 over valid/ready.
module fft_power_spectrum #(
  parameter int Q_IN  = 15,
  parameter int Q_OUT = 15,
  parameter int N     = 8,
  parameter int SHIFT = 15,
  localparam int ADDR_W = $clog2(N/2+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic signed [Q_IN:0]     data_real_0,
  input  logic signed [Q_IN:0]     data_imag_0,
  input  logic signed [Q_IN:0]     data_real_1,
  input  logic signed [Q_IN:0]     data_imag_1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_bin,
  output logic [Q_OUT:0]           out_power,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overflow
);

  localparam int HALF  = N / 2;
  localparam int CNT_W = $clog2(HALF);
  localparam int SQ_W  = 2 * (Q_IN + 1);
  localparam int SUM_W = SQ_W + 1;
  localparam int WW    = (SUM_W > Q_OUT + 1) ? SUM_W : Q_OUT + 1;
  localparam logic [WW-1:0] PMAX = {WW{1'b1}} >> (WW - Q_OUT - 1);

  typedef enum logic [1:0] {
    COLLECT,
    FLUSH_A,
    FLUSH_B,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              last_beat;
  logic              hs;
  logic              drain_done;
  logic [ADDR_W-1:0] nxt_bin;

  logic              s1_valid;
  logic              s1_top;
  logic [CNT_W-1:0]  s1_bin;
  logic [SQ_W-1:0]   sq_re0, sq_im0, sq_re1, sq_im1;

  logic [Q_OUT:0]    mem [0:HALF];

  function automatic logic [SQ_W-1:0] sq(
    input logic signed [Q_IN:0] a
  );
    logic signed [SQ_W-1:0] w;
    w = SQ_W'(a);
    return $unsigned(w * w);
  endfunction

  // sum of squares, truncating shift, then clamp to the output range
  function automatic logic [Q_OUT:0] sat_pow(
    input logic [SQ_W-1:0] a,
    input logic [SQ_W-1:0] b
  );
    logic [SUM_W-1:0] s;
    logic [WW-1:0]    w;
    s = {1'b0, a} + {1'b0, b};
    w = WW'(s >> SHIFT);
    if (w > PMAX) w = PMAX;
    return w[Q_OUT:0];
  endfunction

  assign accept     = valid_in && (state == COLLECT);
  assign last_beat  = accept && (cnt == CNT_W'(HALF - 1));
  assign hs         = out_valid && out_ready;
  assign drain_done = (state == DRAIN) && hs && out_last;
  assign nxt_bin    = out_bin + ADDR_W'(1);
  assign busy       = (state != COLLECT);

  always_comb begin
    state_nx = state;
    unique case (state)
      COLLECT: if (last_beat) state_nx = FLUSH_A;
      FLUSH_A: state_nx = FLUSH_B;
      FLUSH_B: state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = COLLECT;
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      if (valid_in && (state != COLLECT)) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_bin <= cnt;
      s1_top <= (cnt == '0);
      sq_re0 <= sq(data_real_0);
      sq_im0 <= sq(data_imag_0);
      sq_re1 <= sq(data_real_1);
      sq_im1 <= sq(data_imag_1);
    end
  end

  // port 1 carries bin N/2 only on beat 0; later port-1 bins are mirrors
  always_ff @(posedge clk) begin
    if (s1_valid) begin
      mem[ADDR_W'(s1_bin)] <= sat_pow(sq_re0, sq_im0);
      if (s1_top) mem[ADDR_W'(HALF)] <= sat_pow(sq_re1, sq_im1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_power <= '0;
      out_last  <= 1'b0;
    end else if (state == FLUSH_B) begin
      out_valid <= 1'b1;
      out_bin   <= '0;
      out_power <= mem[0];
      out_last  <= 1'b0;
    end else if ((state == DRAIN) && hs) begin
      if (out_last) begin
        out_valid <= 1'b0;
        out_bin   <= '0;
        out_last  <= 1'b0;
      end else begin
        out_bin   <= nxt_bin;
        out_power <= mem[nxt_bin];
        out_last  <= (nxt_bin == ADDR_W'(HALF));
      end
    end
  end

endmodule

// File: tb/tb_fft_power_spectrum.sv
// Directed frame table for fft_power_spectrum: a SHIFT=15 and a SHIFT=0
// instance share stimulus; expected powers are hand-computed per frame.
module tb_fft_power_spectrum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               valid_in;
  logic signed [15:0] d_re0, d_im0, d_re1, d_im1;
  logic               out_ready;

  logic        ov_a, ol_a, busy_a, of_a;
  logic [2:0]  bin_a;
  logic [15:0] pw_a;
  logic        ov_b, ol_b, busy_b, of_b;
  logic [2:0]  bin_b;
  logic [15:0] pw_b;

  fft_power_spectrum #(.Q_IN(15), .Q_OUT(15), .N(8), .SHIFT(15)) dut_a (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .data_real_0(d_re0), .data_imag_0(d_im0),
    .data_real_1(d_re1), .data_imag_1(d_im1),
    .out_valid(ov_a), .out_ready(out_ready), .out_bin(bin_a),
    .out_power(pw_a), .out_last(ol_a), .busy(busy_a), .overflow(of_a)
  );

  fft_power_spectrum #(.Q_IN(15), .Q_OUT(15), .N(8), .SHIFT(0)) dut_b (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .data_real_0(d_re0), .data_imag_0(d_im0),
    .data_real_1(d_re1), .data_imag_1(d_im1),
    .out_valid(ov_b), .out_ready(out_ready), .out_bin(bin_b),
    .out_power(pw_b), .out_last(ol_b), .busy(busy_b), .overflow(of_b)
  );

  typedef struct {
    logic [3:0][15:0] re0, im0, re1, im1;
    logic [4:0][15:0] exp_a, exp_b;
    int               gap [3];
    logic [3:0]       rdy;
    bit               poke;
  } vec_t;

  vec_t tbl [5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clr(input int r);
    tbl[r].re0 = '0; tbl[r].im0 = '0;
    tbl[r].re1 = '0; tbl[r].im1 = '0;
    tbl[r].exp_a = '0; tbl[r].exp_b = '0;
    tbl[r].gap[0] = 0; tbl[r].gap[1] = 0; tbl[r].gap[2] = 0;
    tbl[r].rdy = 4'b1111;
    tbl[r].poke = 1'b0;
  endtask

  task automatic beat(input int r, input int b, input int a0,
                      input int b0, input int a1, input int b1);
    tbl[r].re0[b] = 16'(a0);
    tbl[r].im0[b] = 16'(b0);
    tbl[r].re1[b] = 16'(a1);
    tbl[r].im1[b] = 16'(b1);
  endtask

  task automatic expa(input int r, input int e0, input int e1,
                      input int e2, input int e3, input int e4);
    tbl[r].exp_a[0] = 16'(e0); tbl[r].exp_a[1] = 16'(e1);
    tbl[r].exp_a[2] = 16'(e2); tbl[r].exp_a[3] = 16'(e3);
    tbl[r].exp_a[4] = 16'(e4);
  endtask

  task automatic expb(input int r, input int e0, input int e1,
                      input int e2, input int e3, input int e4);
    tbl[r].exp_b[0] = 16'(e0); tbl[r].exp_b[1] = 16'(e1);
    tbl[r].exp_b[2] = 16'(e2); tbl[r].exp_b[3] = 16'(e3);
    tbl[r].exp_b[4] = 16'(e4);
  endtask

  task automatic send_beats(input int r);
    int lat;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_pre", 32'(busy_a), 0);
      valid_in = 1'b1;
      d_re0 = $signed(tbl[r].re0[i]);
      d_im0 = $signed(tbl[r].im0[i]);
      d_re1 = $signed(tbl[r].re1[i]);
      d_im1 = $signed(tbl[r].im1[i]);
      if (i < 3) begin
        for (int g = 0; g < tbl[r].gap[i]; g++) begin
          @(negedge clk);
          valid_in = 1'b0;
          chk("busy_gap", 32'(busy_a), 0);
        end
      end
    end
    lat = 0;
    do begin
      @(negedge clk);
      valid_in = 1'b0;
      lat++;
      if (lat == 1) chk("busy_post", 32'(busy_a), 1);
    end while (!ov_a && lat < 20);
    chk("latency", 32'(lat), 3);
  endtask

  task automatic run_frame(input int r);
    int          hs;
    int          cyc;
    bit          stalled;
    bit          rd;
    logic [2:0]  sb;
    logic [15:0] spa;
    send_beats(r);
    hs = 0;
    cyc = 0;
    stalled = 1'b0;
    while (hs < 5 && cyc < 64) begin
      rd = tbl[r].rdy[cyc % 4];
      if (ov_a) begin
        if (stalled) begin
          chk("hold_bin", 32'(bin_a), 32'(sb));
          chk("hold_pwr", 32'(pw_a), 32'(spa));
        end
        if (rd) begin
          chk("bin", 32'(bin_a), 32'(hs));
          chk("pwr_a", 32'(pw_a), 32'(tbl[r].exp_a[hs]));
          chk("pwr_b", 32'(pw_b), 32'(tbl[r].exp_b[hs]));
          chk("last", 32'(ol_a), 32'(hs == 4));
          hs++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          sb = bin_a;
          spa = pw_a;
        end
      end else begin
        chk("drain_valid", 32'(ov_a), 1);
      end
      out_ready = rd;
      valid_in = tbl[r].poke && (cyc == 1 || (rd && hs == 5));
      d_re0 = 16'sd1234; d_im0 = -16'sd777;
      d_re1 = 16'sd99;   d_im1 = 16'sd4321;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    valid_in = 1'b0;
    chk("handshakes", 32'(hs), 5);
    chk("valid_after", 32'(ov_a), 0);
    chk("busy_after", 32'(busy_a), 0);
  endtask

  initial begin
    // frame A: single tone pair
    clr(0);
    beat(0, 0, 16384, 0, 0, -16384);
    expa(0, 8192, 0, 0, 0, 8192);
    expb(0, 65535, 0, 0, 0, 65535);
    // frame B: saturation and mixed values, gapped beats
    clr(1);
    beat(1, 0, -32768, -32768, -32768, 0);
    beat(1, 1, 1000, 2000, 32767, 32767);
    beat(1, 2, -12345, 6789, -1, -1);
    beat(1, 3, 0, 32767, 5, 5);
    expa(1, 65535, 152, 6057, 32766, 32768);
    expb(1, 65535, 65535, 65535, 65535, 65535);
    tbl[1].gap[0] = 2; tbl[1].gap[1] = 0; tbl[1].gap[2] = 3;
    // same frame back-to-back
    tbl[2] = tbl[1];
    tbl[2].gap[0] = 0; tbl[2].gap[2] = 0;
    // small values for the unshifted instance, backpressure, drops
    clr(3);
    beat(3, 0, 3, 4, 0, 1);
    beat(3, 1, -5, 12, 7, 7);
    beat(3, 2, 100, -100, 0, 0);
    beat(3, 3, 255, 0, 0, 0);
    expa(3, 0, 0, 0, 1, 0);
    expb(3, 25, 169, 20000, 65025, 1);
    tbl[3].rdy = 4'b1001;
    tbl[3].poke = 1'b1;
    tbl[4] = tbl[0];

    reset = 1'b1;
    valid_in = 1'b0;
    out_ready = 1'b0;
    d_re0 = '0; d_im0 = '0; d_re1 = '0; d_im1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ov_a), 0);
    chk("rst_bin", 32'(bin_a), 0);
    chk("rst_pwr", 32'(pw_a), 0);
    chk("rst_last", 32'(ol_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_ovf", 32'(of_a), 0);
    reset = 1'b0;

    for (int r = 0; r < 5; r++) begin
      run_frame(r);
      chk("overflow", 32'(of_a), 32'(r >= 3));
    end

    // abort mid-drain after bin 2
    send_beats(3);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_bin", 32'(bin_a), 3);
    out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(ov_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_ovf", 32'(of_a), 0);
    reset = 1'b0;
    run_frame(0);
    chk("final_ovf", 32'(of_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
